// File: rtl/nios2_dbg_slave_sysclk_queue.sv
// System-clock side of the Nios II JTAG debug slave: strobe synchronisers, IR capture and a command FIFO.
// Optional feature: define NIOS2_DBG_SLAVE_TIMESTAMP_EN to stamp each queued command (adds cmd_ts).
module nios2_dbg_slave_sysclk_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TS_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vs_udr,
  input  logic                      vs_uir,
  input  logic [IR_WIDTH-1:0]       ir_in,
  input  logic [SR_WIDTH-1:0]       sr,
  input  logic                      cmd_ready,
  input  logic                      clr_ovf,
  output logic [SR_WIDTH-1:0]       jdo,
  output logic [IR_WIDTH-1:0]       cmd_ir,
  output logic                      cmd_valid,
  output logic [2**IR_WIDTH-1:0]    take_action,
  output logic [2**IR_WIDTH-1:0]    take_no_action,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      ovf
`ifdef NIOS2_DBG_SLAVE_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]       cmd_ts
`endif
);

  localparam int NUM_IR = 2**IR_WIDTH;
  localparam int AW     = $clog2(DEPTH);
`ifdef NIOS2_DBG_SLAVE_TIMESTAMP_EN
  localparam int TS_W   = TS_WIDTH;
`else
  localparam int TS_W   = 0 * TS_WIDTH;  // no timestamp field in storage
`endif
  localparam int CMD_W   = SR_WIDTH + IR_WIDTH;
  localparam int ENTRY_W = CMD_W + TS_W;

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
  logic                   udr_q, uir_q;
  logic                   udr_rise, uir_rise;
  logic [IR_WIDTH-1:0]    ir_reg;

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0]     head;
  logic [ENTRY_W-1:0]     entry;
  logic                   full, pop, push;

  // Rise pulses are registered so the push lands SYNC_STAGES+1 edges after vs_udr is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      udr_q    <= 1'b0;
      uir_q    <= 1'b0;
      udr_rise <= 1'b0;
      uir_rise <= 1'b0;
      ir_reg   <= '0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_q    <= udr_sync[SYNC_STAGES-1];
      uir_q    <= uir_sync[SYNC_STAGES-1];
      udr_rise <= udr_sync[SYNC_STAGES-1] & ~udr_q;
      uir_rise <= uir_sync[SYNC_STAGES-1] & ~uir_q;
      if (uir_rise) ir_reg <= ir_in;
    end
  end

`ifdef NIOS2_DBG_SLAVE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  assign entry  = {ts_cnt, ir_reg, sr};
  assign cmd_ts = head[ENTRY_W-1 -: TS_WIDTH];
`else
  assign entry  = {ir_reg, sr};
`endif

  assign fifo_level = wr_ptr - rd_ptr;
  assign cmd_valid  = (wr_ptr != rd_ptr);
  assign full       = (fifo_level == (AW+1)'(DEPTH));
  assign pop        = cmd_valid & cmd_ready;
  assign push       = udr_rise & (~full | pop);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign {cmd_ir, jdo} = head[CMD_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // A fresh drop outranks a clear request in the same cycle.
      if (udr_rise && full && !pop) ovf <= 1'b1;
      else if (clr_ovf)             ovf <= 1'b0;
    end
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    for (int k = 0; k < NUM_IR; k++) begin
      if (pop && (cmd_ir == IR_WIDTH'(k))) begin
        if (jdo[SR_WIDTH-1]) take_action[k]    = 1'b1;
        else                 take_no_action[k] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios2_dbg_slave_sysclk_queue.sv
// Scoreboard bench for nios2_dbg_slave_sysclk_queue: stimulus queues expected commands, a monitor checks each pop.
module tb_nios2_dbg_slave_sysclk_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vs_udr, vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_ready, clr_ovf;
  logic [37:0] jdo;
  logic [1:0]  cmd_ir;
  logic        cmd_valid;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;
  logic        ovf;
`ifdef NIOS2_DBG_SLAVE_TIMESTAMP_EN
  logic [15:0] cmd_ts;
`endif

  int errors = 0;
  int checks = 0;
  logic [39:0] sb [$];   // {ir, sr}

  nios2_dbg_slave_sysclk_queue dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .clr_ovf(clr_ovf),
    .jdo(jdo), .cmd_ir(cmd_ir), .cmd_valid(cmd_valid),
    .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .ovf(ovf)
`ifdef NIOS2_DBG_SLAVE_TIMESTAMP_EN
    , .cmd_ts(cmd_ts)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the oldest expected command.
  always @(negedge clk) begin
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", {24'b0, cmd_ir, jdo}, 64'hdead);
      end else begin
        logic [39:0] e;
        logic [3:0]  onehot;
        e = sb.pop_front();
        onehot = 4'b0001 << e[39:38];
        check("pop_jdo", 64'(jdo), 64'(e[37:0]));
        check("pop_cmd_ir", 64'(cmd_ir), 64'(e[39:38]));
        check("pop_take_action", 64'(take_action), e[37] ? 64'(onehot) : 64'h0);
        check("pop_take_no_action", 64'(take_no_action), e[37] ? 64'h0 : 64'(onehot));
      end
    end else begin
      check("idle_take", {56'b0, take_action, take_no_action}, 64'h0);
    end
  end

  // Strobe pulse: held two sampling edges, then inputs kept stable until the push edge is well past.
  task automatic strobe(input logic udr, input logic uir, input logic [37:0] s, input logic [1:0] ir);
    sr = s;
    ir_in = ir;
    vs_udr = udr;
    vs_uir = uir;
    repeat (2) @(posedge clk);
    #1;
    vs_udr = 1'b0;
    vs_uir = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] exp_ir, input logic [37:0] s, input logic [1:0] ir_drive);
    sb.push_back({exp_ir, s});
    strobe(1'b1, 1'b0, s, ir_drive);
  endtask

  task automatic drain(input string name);
    cmd_ready = 1'b1;
    for (int i = 0; i < 20 && cmd_valid; i++) @(posedge clk);
    #1;
    check(name, 64'(cmd_valid), 64'h0);
  endtask

  initial begin
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = 2'd0;
    sr = '0; cmd_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    check("rst_cmd_valid", 64'(cmd_valid), 64'h0);
    check("rst_level", 64'(fifo_level), 64'h0);
    check("rst_ovf", 64'(ovf), 64'h0);
    check("rst_jdo", 64'(jdo), 64'h0);
    check("rst_cmd_ir", 64'(cmd_ir), 64'h0);
    check("rst_take", {56'b0, take_action, take_no_action}, 64'h0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // IR=1, then action command with latency check
    strobe(1'b0, 1'b1, '0, 2'd1);
    cmd_ready = 1'b1;
    sb.push_back({2'd1, 38'h20_0000_00AB});
    sr = 38'h20_0000_00AB;
    vs_udr = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("latency_edge%0d", e), 64'(cmd_valid), (e == 3) ? 64'h1 : 64'h0);
      if (e == 1) vs_udr = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    check("after_pop_valid", 64'(cmd_valid), 64'h0);
    check("after_pop_level", 64'(fifo_level), 64'h0);
    @(posedge clk); #1;

    push_cmd(2'd1, 38'h00_0000_00CD, 2'd1);

    // Overflow: six pushes into a stalled 4-deep queue
    cmd_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) push_cmd(2'd1, 38'(i), 2'd1);
      else        strobe(1'b1, 1'b0, 38'(i), 2'd1);
    end
    check("ovf_level", 64'(fifo_level), 64'h4);
    check("ovf_set", 64'(ovf), 64'h1);
    drain("ovf_drain_empty");
    check("ovf_sticky", 64'(ovf), 64'h1);
    clr_ovf = 1'b1;
    @(posedge clk); #1;
    clr_ovf = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'h0);

    // Full queue: push coincident with pop
    cmd_ready = 1'b0;
    for (int i = 10; i <= 13; i++) push_cmd(2'd1, 38'(i), 2'd1);
    check("full_level", 64'(fifo_level), 64'h4);
    sb.push_back({2'd1, 38'd14});
    sr = 38'd14;
    vs_udr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 vs_udr = 1'b0;
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(posedge clk); #1 cmd_ready = 1'b0;
    check("pushpop_level", 64'(fifo_level), 64'h4);
    check("pushpop_ovf", 64'(ovf), 64'h0);
    repeat (3) @(posedge clk); #1;
    drain("pushpop_drain_empty");

    // Coincident update-IR and update-DR
    strobe(1'b0, 1'b1, '0, 2'd0);
    cmd_ready = 1'b1;
    sb.push_back({2'd0, 38'h20_0000_0077});
    strobe(1'b1, 1'b1, 38'h20_0000_0077, 2'd3);
    push_cmd(2'd3, 38'h00_0000_0088, 2'd3);

    // Reset with queued commands and the consumer ready
    cmd_ready = 1'b0;
    for (int i = 21; i <= 23; i++) strobe(1'b1, 1'b0, 38'(i), 2'd3);
    check("pre_reset_level", 64'(fifo_level), 64'h3);
    cmd_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    check("reset_valid", 64'(cmd_valid), 64'h0);
    check("reset_level", 64'(fifo_level), 64'h0);
    check("reset_take", {56'b0, take_action, take_no_action}, 64'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    push_cmd(2'd0, 38'h20_0000_0055, 2'd0);
    repeat (4) @(posedge clk); #1;
    check("post_reset_level", 64'(fifo_level), 64'h0);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
